// File: rtl/chia9bit_seq.sv
// Sequential restoring divider: WN-bit dividend by WD-bit divisor, one quotient bit per clock.
// Optional divide-by-zero short cut and dz flag: define CHIA_DIV_ZERO_DETECT_EN.
module chia9bit_seq #(
  parameter int unsigned WN = 9,
  parameter int unsigned WD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] q,
  output logic [WD-1:0] r
`ifdef CHIA_DIV_ZERO_DETECT_EN
  ,
  output logic          dz
`endif
);

  localparam int unsigned CW = $clog2(WN);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_d;
  logic [WN-1:0] sh, sh_d, q_d;
  logic [WD-1:0] pr, pr_d, dvs, dvs_d, r_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          busy_d, done_d;
  logic [WD:0]   pr_sh;
  logic          ge;
  logic [WD-1:0] pr_nx;
  logic [WN-1:0] sh_nx;
  logic          accept;
`ifdef CHIA_DIV_ZERO_DETECT_EN
  logic          dz_d;
`endif

  // One restoring step: the WD+1-bit window absorbs the shifted-in bit, so the compare cannot overflow.
  always_comb begin
    pr_sh = {pr, sh[WN-1]};
    ge    = pr_sh >= {1'b0, dvs};
    pr_nx = ge ? WD'(pr_sh - {1'b0, dvs}) : pr_sh[WD-1:0];
    sh_nx = {sh[WN-2:0], ge};
  end

  assign accept = start && (state != RUN);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    sh_d    = sh;
    pr_d    = pr;
    dvs_d   = dvs;
    cnt_d   = cnt;
    q_d     = q;
    r_d     = r;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef CHIA_DIV_ZERO_DETECT_EN
    dz_d    = dz;
`endif
    case (state)
      RUN: begin
        pr_d  = pr_nx;
        sh_d  = sh_nx;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WN - 1)) begin
          state_d = FIN;
          q_d     = sh_nx;
          r_d     = pr_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in IDLE or FIN launches a new operation; FIN's done drops on this edge.
    if (accept) begin
      dvs_d   = divisor;
      sh_d    = dividend;
      pr_d    = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = RUN;
`ifdef CHIA_DIV_ZERO_DETECT_EN
      dz_d    = 1'b0;
      if (divisor == '0) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        q_d     = '1;
        r_d     = '0;
        dz_d    = 1'b1;
      end
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      pr    <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CHIA_DIV_ZERO_DETECT_EN
      dz    <= 1'b0;
`endif
    end else begin
      state <= state_d;
      sh    <= sh_d;
      pr    <= pr_d;
      dvs   <= dvs_d;
      cnt   <= cnt_d;
      q     <= q_d;
      r     <= r_d;
      busy  <= busy_d;
      done  <= done_d;
`ifdef CHIA_DIV_ZERO_DETECT_EN
      dz    <= dz_d;
`endif
    end
  end

endmodule

// File: doc/chia9bit_seq.md
Name: chia9bit_seq

Overview:
- Sequential restoring divider: splits a 9-bit sum-of-products value back into quotient and remainder by a 4-bit operand.
- Inverse of the multiply-accumulate datapath. Consumes the same 9-bit result width produced by the 4x4 multiply / 8-bit add chain.
- One quotient bit per clock. Start/busy/done handshake.
- Used where a combined product sum must be normalised or averaged by a small factor.

Parameters:
- WN, 9, dividend and quotient width in bits; iteration count equals WN.
- WD, 4, divisor and remainder width in bits.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset. Asserting it immediately clears all state; release is sampled on clk.
- start  input  1  request. Accepted only on a rising clk edge where busy==0.
- dividend  input  WN  numerator, sampled on the accepting edge only.
- divisor  input  WD  denominator, sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; q and r are valid from this cycle on.
- q  output  WN  quotient, held until the next accepted start.
- r  output  WD  remainder, held until the next accepted start.
- dz  output  1  divide-by-zero flag. Exists only when the optional feature is compiled in.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, q=0, r=0, dz=0; iteration counter=0; internal registers=0.
- States: IDLE -> RUN -> FIN -> IDLE. FIN lasts exactly one cycle.
- Accept (IDLE or FIN with start=1):
  - Latch divisor.
  - Load dividend into the shift register.
  - Clear the (WD+1)-bit partial remainder.
  - count=0, busy=1, dz=0, then go to RUN.
- RUN, each edge:
  - pr = {pr[WD-1:0], msb of shift reg}; shift reg shifts left.
  - If pr >= divisor: pr = pr - divisor and the new quotient bit is 1; otherwise the new quotient bit is 0.
  - The new quotient bit enters the shift register LSB.
  - count increments. The edge with count==WN-1 moves to FIN.
- FIN: q = shift reg, r = pr[WD-1:0], done=1, busy=0.
- Latency: accept at edge E0, done high in the cycle after edge E(WN), so 9 RUN edges by default. Back-to-back ops are possible: a start in the FIN cycle is accepted, and done falls on that edge.
- start while busy=1 is ignored, with no effect on the running operation. Operands changing while busy have no effect.
- done is high for exactly one cycle per accepted op. busy and done are never high together.
- Outputs q and r keep their previous values during RUN and update only on entry to FIN.
- Width rule: the partial remainder is WD+1 bits, so the compare never overflows. The result always satisfies q*divisor + r == dividend and r < divisor (divisor != 0).
- rst_n asserted mid-RUN: operation aborted, all outputs go to reset values, and no done is produced.
- Without the optional feature, divisor 0 runs the normal WN iterations and yields q = all ones (9'h1FF), r = dividend[WD-1:0].

Optional Feature:
- Macro: CHIA_DIV_ZERO_DETECT_EN.
- Defined:
  - dz port present.
  - On accept with divisor==0, go directly to FIN without entering RUN. done appears in the cycle after the accepting edge (latency 1), with q=9'h1FF, r=0, dz=1.
  - dz is held until the next accepted start and cleared by reset.
  - Nonzero divisors behave exactly as without the macro, with dz=0.
- Not defined: no dz port; divisor 0 takes the normal 9-cycle path with the result stated in Behaviour.

Test Plan:
- Reset, then dividend=110, divisor=7, start pulse -> busy for 9 cycles, done one cycle later, q=15, r=5; busy=0 in the done cycle.
- dividend=142 / 11, then in the FIN cycle start with 120 / 5 -> first done gives q=12, r=10; second done exactly 10 cycles later gives q=24, r=0. q holds 12 in between.
- dividend=511 / 15 with start re-pulsed and operands changed to 3/1 during busy -> q=34, r=1; the second start is ignored, and exactly one done occurs.
- Assert rst_n=0 mid-RUN (at iteration 4 of 100 / 3) -> busy, done, q, r immediately 0; no done after release; a new 100 / 3 gives q=33, r=1.
- dividend=100, divisor=0:
  - with CHIA_DIV_ZERO_DETECT_EN -> done 1 cycle after accept, q=9'h1FF, r=0, dz=1;
  - without it -> done after 9 RUN cycles, q=9'h1FF, r=4.
- Sweep all dividend 0..511 x divisor 1..15 -> q*divisor+r==dividend and r<divisor on every done.
